// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes with sign fix-up at the final select.
//
// state | meaning
// IDLE  | waiting for start; result holds the last completed value
// RUN   | XLEN iterations of shift-add or shift-subtract
// FIN   | result registered, done pulses for this one cycle
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t          state;
   logic [2:0]      op;
   logic            neg;
   logic [XLEN-1:0] opnd;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]   cnt;

   logic            is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in, neg_in;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] a_mag, b_mag, early_res;

   assign is_div_in = funct3[2];
   assign a_sgn_in  = is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign b_sgn_in  = is_div_in ? ~funct3[0] : ~funct3[1];
   assign a_neg_in  = a_sgn_in & rs1[XLEN-1];
   assign b_neg_in  = b_sgn_in & rs2[XLEN-1];
   assign a_mag     = a_neg_in ? -rs1 : rs1;
   assign b_mag     = b_neg_in ? -rs2 : rs2;
   // Remainder takes the dividend's sign; everything else the XOR of both.
   assign neg_in    = (is_div_in & funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
   assign div_zero  = is_div_in && (rs2 == '0);
   assign div_ovf   = is_div_in && !funct3[0] && (rs1 == MIN_INT) && (rs2 == '1);

   always_comb begin
      early_res = '0;
      if (div_zero)
         early_res = funct3[1] ? rs1 : '1;
      else if (!funct3[1])
         early_res = MIN_INT;
   end

   logic [XLEN:0]     sum, shifted, diff;
   logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod;
   logic [XLEN-1:0]   quo, rmd, fix_res;

   // Multiply: upper half accumulates, lower half shifts out the multiplier.
   assign sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_nxt = {sum, acc[XLEN-1:1]};

   // Divide: upper half is the partial remainder, lower half dividend/quotient.
   assign shifted = acc[2*XLEN-1:XLEN-1];
   assign diff    = shifted - {1'b0, opnd};
   assign div_nxt = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

   assign acc_nxt = op[2] ? div_nxt : mul_nxt;
   assign prod    = neg ? -acc_nxt : acc_nxt;
   assign quo     = neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
   assign rmd     = neg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

   always_comb begin
      fix_res = '0;
      case (op)
         3'b000:                 fix_res = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_res = quo;
         default:                fix_res = rmd;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op     <= '0;
         neg    <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else if (kill) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op   <= funct3;
                  neg  <= neg_in;
                  cnt  <= '0;
                  busy <= 1'b1;
                  acc  <= {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
                  opnd <= is_div_in ? b_mag : a_mag;
                  if (div_zero || div_ovf) begin
                     state  <= FIN;
                     result <= early_res;
                     done   <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(XLEN-1)) begin
                  state  <= FIN;
                  result <= fix_res;
                  done   <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model with per-cycle compare,
// directed corner cases, then randomized start/kill/rst traffic.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        busy, done;
   logic [31:0] result;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   muldiv_seq #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1(rs1), .rs2(rs2), .kill(kill),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa, sb, ps;
      longint unsigned ua, ub, pu;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      r  = '0;
      case (f)
         3'd0: begin ps = sa * sb; r = ps[31:0]; end
         3'd1: begin ps = sa * sb; r = ps[63:32]; end
         3'd2: begin ps = sa * longint'(ub); r = ps[63:32]; end
         3'd3: begin pu = ua * ub; r = pu[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
            else begin ps = sa / sb; r = ps[31:0]; end
         end
         3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
            else begin ps = sa % sb; r = ps[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
         return 1;
      return 33;
   endfunction

   // Model: number of busy cycles left after each edge; done is the last of them.
   int          rem_c = 0;
   logic [31:0] exp_res = '0;
   logic [31:0] pend = '0;

   always @(posedge clk) begin
      if (rst) begin
         rem_c   = 0;
         exp_res = '0;
      end else if (kill) begin
         rem_c = 0;
      end else if (rem_c == 0) begin
         if (start) begin
            pend  = ref_calc(funct3, rs1, rs2);
            rem_c = ref_lat(funct3, rs1, rs2);
            if (rem_c == 1) exp_res = pend;
         end
      end else begin
         rem_c--;
         if (rem_c == 1) exp_res = pend;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc busy", busy, (rem_c > 0));
         check("cyc done", done, (rem_c == 1));
         check("cyc result", result, exp_res);
      end
   end

   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit hold,
                        input string name);
      int lat = 0;
      int ndone = 0;
      @(negedge clk);
      funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (!hold) start = 1'b0;
         if (done) begin
            ndone++;
            break;
         end
      end
      start = 1'b0;
      check({name, " done"}, ndone, 1);
      check({name, " latency"}, lat, exp_lat);
      check({name, " result"}, result, exp);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int nd;
      rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset result", result, 0);

      check("pin mul", ref_calc(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
      check("pin mulh", ref_calc(3'd1, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFFF);
      check("pin mulhu", ref_calc(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
      check("pin mulhsu", ref_calc(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
      check("pin div", ref_calc(3'd4, -32'sd20, 32'd6), 32'hFFFFFFFD);
      check("pin rem", ref_calc(3'd6, -32'sd20, 32'd6), 32'hFFFFFFFE);
      check("pin divu0", ref_calc(3'd5, 32'h1234, 32'd0), 32'hFFFFFFFF);
      check("pin remu0", ref_calc(3'd7, 32'h1234, 32'd0), 32'h1234);
      check("pin divovf", ref_calc(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);

      do_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, "mul");
      do_op(3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 0, "mulh");
      do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "mulhu");
      do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, "mulhsu");
      do_op(3'd4, -32'sd20, 32'd6, 32'hFFFFFFFD, 33, 0, "div");
      do_op(3'd6, -32'sd20, 32'd6, 32'hFFFFFFFE, 33, 0, "rem");
      do_op(3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, 0, "divu0");
      do_op(3'd7, 32'h1234, 32'd0, 32'h1234, 1, 0, "remu0");
      do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "divovf");
      do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0, "removf");
      do_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1, "mul hold");
      @(negedge clk);
      check("hold no reaccept", busy, 0);
      do_op(3'd5, 32'd20, 32'd6, 32'd3, 33, 0, "divu");

      // kill together with start in IDLE accepts nothing
      @(negedge clk);
      start = 1'b1; kill = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check("kill+start busy", busy, 0);

      // kill mid-run
      funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill busy", busy, 0);
      check("kill result", result, 32'd3);
      nd = 0;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("kill no done", nd, 0);

      // reset mid-run
      funct3 = 3'd1; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst result", result, 0);
      do_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 0, "mul after rst");

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         start  = ($urandom_range(0, 9) < 3);
         kill   = ($urandom_range(0, 149) == 0);
         rst    = ($urandom_range(0, 799) == 0);
         funct3 = 3'($urandom_range(0, 7));
         rs1    = pick();
         rs2    = pick();
      end
      @(negedge clk);
      start = 1'b0; kill = 1'b0; rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
